// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one iteration per cycle, with a fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_I,
    input  logic            rst_I,
    input  logic            valid_I,
    input  logic [2:0]      op_I,
    input  logic [XLEN-1:0] regA_I,
    input  logic [XLEN-1:0] regB_I,
    input  logic            kill_I,
    output logic            ready_O,
    output logic            valid_O,
    output logic [XLEN-1:0] result_O
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   res_q;
    logic [2*XLEN-1:0] acc;
    logic              neg_q;
    logic              neg_r;

    logic              is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag_in, b_mag_in, fast_res;

    always_comb begin
        is_div   = op_I[2];
        sgn_a    = (op_I == 3'b001) || (op_I == 3'b010) || (op_I == 3'b100) || (op_I == 3'b110);
        sgn_b    = (op_I == 3'b001) || (op_I == 3'b100) || (op_I == 3'b110);
        a_neg    = sgn_a && regA_I[XLEN-1];
        b_neg    = sgn_b && regB_I[XLEN-1];
        a_mag_in = a_neg ? -regA_I : regA_I;
        b_mag_in = b_neg ? -regB_I : regB_I;
        div_zero = is_div && (regB_I == '0);
        div_ovf  = is_div && !op_I[0] && (regA_I == {1'b1, {(XLEN-1){1'b0}}}) && (regB_I == '1);
        if (div_zero) fast_res = op_I[1] ? regA_I : '1;
        else          fast_res = op_I[1] ? '0 : regA_I;
    end

    // acc holds {high, low} of the product for multiply and {remainder, quotient} for divide
    logic [XLEN:0]     mul_sum, div_diff;
    logic [XLEN-1:0]   new_rem;
    logic              qbit;
    logic [2*XLEN-1:0] mul_next, div_next, prod_s;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
        mul_next = {mul_sum, acc[XLEN-1:1]};
        div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        qbit     = !div_diff[XLEN];
        new_rem  = qbit ? div_diff[XLEN-1:0] : acc[2*XLEN-2:XLEN-1];
        div_next = {new_rem, acc[XLEN-2:0], qbit};
        prod_s   = neg_q ? -acc : acc;
        quo      = acc[XLEN-1:0];
        rem      = acc[2*XLEN-1:XLEN];
        case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100:                 fix_res = neg_q ? -quo : quo;
            3'b101:                 fix_res = quo;
            3'b110:                 fix_res = neg_r ? -rem : rem;
            default:                fix_res = rem;
        endcase
    end

    assign ready_O = (state == IDLE);

    // result_O is only loaded on the DONE->IDLE edge so a kill in DONE leaves it untouched
    always_ff @(posedge clk_I or posedge rst_I) begin
        if (rst_I) begin
            state    <= IDLE;
            count    <= '0;
            op_q     <= '0;
            opnd     <= '0;
            res_q    <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            valid_O  <= 1'b0;
            result_O <= '0;
        end else begin
            valid_O <= 1'b0;
            if (kill_I) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (valid_I) begin
                        op_q  <= op_I;
                        count <= '0;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        opnd  <= is_div ? b_mag_in : a_mag_in;
                        acc   <= {{XLEN{1'b0}}, (is_div ? a_mag_in : b_mag_in)};
                        if (div_zero || div_ovf) begin
                            res_q <= fast_res;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc   <= op_q[2] ? div_next : mul_next;
                        count <= count + 1'b1;
                        if (count == LAST) state <= FIX;
                    end
                    FIX: begin
                        res_q <= fix_res;
                        state <= DONE;
                    end
                    default: begin
                        result_O <= res_q;
                        valid_O  <= 1'b1;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
